// File: rtl/adma_descriptor_fetch.sv
// ADMA2 descriptor fetch engine.
// Walks a table of 96-bit descriptors through a 32-bit read port. Each
// descriptor is decoded, and every tran descriptor is handed to the
// downstream transfer stage as a length/address pair.
//
//  state   | meaning
//  --------+------------------------------------------------------------
//  ST_STOP | idle; waits for ADMA_START
//  ST_FDS  | fetching the three words of the descriptor at ptr_q
//  ST_CADR | one-cycle decode of the fetched descriptor
//  ST_TFR  | transfer stage owns the bus until transferencia_finalizada

module adma_descriptor_fetch #(
    parameter int unsigned DESC_BYTES = 12,
    parameter int unsigned WORD_BYTES = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        ADMA_START,
    input  logic        ADMA_ABORT,
    input  logic [63:0] ADMA_SYS_ADDR,
    output logic        MEM_RD_REQ,
    output logic [63:0] MEM_RD_ADR,
    input  logic        MEM_RD_ACK,
    input  logic [31:0] MEM_RD_DATA,
    output logic        Permiso_Transf,
    output logic        Data_Transfer_Direction_Select_o,
    input  logic        DIR_IN,
    output logic [15:0] DAT_LEN,
    output logic [63:0] DAT_ADR,
    input  logic        transferencia_finalizada,
    output logic        ADMA_BUSY,
    output logic        ADMA_DONE,
    output logic        ADMA_INT,
    output logic        ADMA_ERROR,
    output logic [63:0] ADMA_ERR_ADR
);

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_FDS  = 2'd1,
        ST_CADR = 2'd2,
        ST_TFR  = 2'd3
    } state_t;

    localparam logic [63:0] DESC_STRIDE = 64'(DESC_BYTES);
    localparam logic [63:0] WORD_STRIDE = 64'(WORD_BYTES);
    localparam logic [1:0]  ACT_TRAN    = 2'b10;
    localparam logic [1:0]  ACT_LINK    = 2'b11;

    state_t      state_q;
    logic [63:0] ptr_q;
    logic [63:0] rd_adr_q;
    logic [1:0]  wcnt_q;
    logic        req_q;
    logic [31:0] w0_q;
    logic [31:0] w1_q;
    logic [31:0] w2_q;
    logic        permiso_q;
    logic        dir_q;
    logic [15:0] dat_len_q;
    logic [63:0] dat_adr_q;
    logic        done_q;
    logic        int_q;
    logic        err_q;
    logic [63:0] err_adr_q;

    logic        d_valid;
    logic        d_end;
    logic        d_int;
    logic [1:0]  d_act;
    logic [63:0] d_addr;
    logic [63:0] seq_ptr_d;
    logic [63:0] next_ptr_d;

    // Field decode of the captured descriptor and candidate next pointers.
    always_comb begin
        d_valid    = w0_q[0];
        d_end      = w0_q[1];
        d_int      = w0_q[2];
        d_act      = w0_q[5:4];
        d_addr     = {w2_q, w1_q};
        seq_ptr_d  = ptr_q + DESC_STRIDE;
        next_ptr_d = (d_act == ACT_LINK) ? d_addr : seq_ptr_d;
    end

    // Table-walk FSM; abort overrides every transition, including a same-cycle ACK.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= ST_STOP;
            ptr_q     <= '0;
            rd_adr_q  <= '0;
            wcnt_q    <= '0;
            req_q     <= 1'b0;
            w0_q      <= '0;
            w1_q      <= '0;
            w2_q      <= '0;
            permiso_q <= 1'b0;
            dir_q     <= 1'b0;
            dat_len_q <= '0;
            dat_adr_q <= '0;
            done_q    <= 1'b0;
            int_q     <= 1'b0;
            err_q     <= 1'b0;
            err_adr_q <= '0;
        end else begin
            done_q <= 1'b0;
            int_q  <= 1'b0;
            if (ADMA_ABORT) begin
                state_q   <= ST_STOP;
                req_q     <= 1'b0;
                permiso_q <= 1'b0;
                wcnt_q    <= '0;
            end else begin
                case (state_q)
                    ST_STOP: begin
                        if (ADMA_START) begin
                            ptr_q    <= ADMA_SYS_ADDR;
                            rd_adr_q <= ADMA_SYS_ADDR;
                            err_q    <= 1'b0;
                            dir_q    <= DIR_IN;
                            wcnt_q   <= '0;
                            req_q    <= 1'b1;
                            state_q  <= ST_FDS;
                        end
                    end
                    ST_FDS: begin
                        if (MEM_RD_ACK) begin
                            case (wcnt_q)
                                2'd0:    w0_q <= MEM_RD_DATA;
                                2'd1:    w1_q <= MEM_RD_DATA;
                                default: w2_q <= MEM_RD_DATA;
                            endcase
                            if (wcnt_q == 2'd2) begin
                                wcnt_q  <= '0;
                                req_q   <= 1'b0;
                                state_q <= ST_CADR;
                            end else begin
                                wcnt_q   <= wcnt_q + 2'd1;
                                rd_adr_q <= rd_adr_q + WORD_STRIDE;
                            end
                        end
                    end
                    ST_CADR: begin
                        if (!d_valid) begin
                            err_q     <= 1'b1;
                            err_adr_q <= ptr_q;
                            state_q   <= ST_STOP;
                        end else if (d_act == ACT_TRAN) begin
                            dat_len_q <= w0_q[31:16];
                            dat_adr_q <= d_addr;
                            permiso_q <= 1'b0;
                            state_q   <= ST_TFR;
                        end else begin
                            // nop, reserved and link complete right here.
                            int_q <= d_int;
                            if (d_end) begin
                                // A terminal link is not followed.
                                if (d_act != ACT_LINK) begin
                                    ptr_q <= seq_ptr_d;
                                end
                                done_q  <= 1'b1;
                                state_q <= ST_STOP;
                            end else begin
                                ptr_q    <= next_ptr_d;
                                rd_adr_q <= next_ptr_d;
                                req_q    <= 1'b1;
                                state_q  <= ST_FDS;
                            end
                        end
                    end
                    ST_TFR: begin
                        if (!permiso_q) begin
                            // Completion left high by the previous transfer must drop first.
                            if (!transferencia_finalizada) begin
                                permiso_q <= 1'b1;
                            end
                        end else if (transferencia_finalizada) begin
                            permiso_q <= 1'b0;
                            ptr_q     <= seq_ptr_d;
                            int_q     <= d_int;
                            if (d_end) begin
                                done_q  <= 1'b1;
                                state_q <= ST_STOP;
                            end else begin
                                rd_adr_q <= seq_ptr_d;
                                req_q    <= 1'b1;
                                state_q  <= ST_FDS;
                            end
                        end
                    end
                    default: state_q <= ST_STOP;
                endcase
            end
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        MEM_RD_REQ                       = req_q;
        MEM_RD_ADR                       = rd_adr_q;
        Permiso_Transf                   = permiso_q;
        Data_Transfer_Direction_Select_o = dir_q;
        DAT_LEN                          = dat_len_q;
        DAT_ADR                          = dat_adr_q;
        ADMA_BUSY                        = (state_q != ST_STOP);
        ADMA_DONE                        = done_q;
        ADMA_INT                         = int_q;
        ADMA_ERROR                       = err_q;
        ADMA_ERR_ADR                     = err_adr_q;
    end

endmodule
